// File: rtl/adder_bist_ctrl_if.sv
// adder_bist_ctrl_if: bundle between the BIST sequencer and the adders under test.
//   master (sequencer): takes start/abort/seed/ref_sum/dut_sum and drives
//     op_a/op_b, busy/done/all_pass, the counters and first_fail_*.
//   slave (environment): the mirror image of master.
interface adder_bist_ctrl_if #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
);
  logic             start;
  logic             abort;
  logic [31:0]      seed;
  logic [WIDTH-1:0] ref_sum;
  logic [WIDTH-1:0] dut_sum;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic             all_pass;
  logic [CNT_W-1:0] test_count;
  logic [CNT_W-1:0] pass_count;
  logic [CNT_W-1:0] fail_count;
  logic [CNT_W-1:0] first_fail_idx;
  logic             first_fail_vld;
  modport master (
    input  start, abort, seed, ref_sum, dut_sum,
    output op_a, op_b, busy, done, all_pass,
           test_count, pass_count, fail_count, first_fail_idx, first_fail_vld
  );
  modport slave (
    output start, abort, seed, ref_sum, dut_sum,
    input  op_a, op_b, busy, done, all_pass,
           test_count, pass_count, fail_count, first_fail_idx, first_fail_vld
  );
endinterface

// File: rtl/adder_bist_ctrl.sv
// adder_bist_ctrl: LFSR-driven BIST sequencer comparing a golden adder against a DUT adder.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset.
//   bus        : adder_bist_ctrl_if.master (control, operands, sums, status, statistics).
module adder_bist_ctrl #(
  parameter int WIDTH         = 64,
  parameter int NUM_TESTS     = 10000,
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 16
) (
  input logic               clk,
  input logic               rst_n,
  adder_bist_ctrl_if.master bus
);
  localparam int K = (WIDTH + 31) / 32;
  typedef enum logic [2:0] {IDLE, GEN_A, GEN_B, SETTLE, CHECK, DONE} state_t;
  state_t           r_state, w_next;
  logic [31:0]      r_lfsr, w_draw;
  logic [WIDTH-1:0] r_sh_a, r_sh_b, r_op_a, r_op_b;
  logic [3:0]       r_cnt;
  logic [CNT_W-1:0] r_test, r_pass, r_fail, r_ffi, w_test_inc;
  logic             r_ffv, w_busy, w_start, w_abort, w_last;
  assign w_draw     = (r_lfsr >> 1) ^ (r_lfsr[0] ? 32'h8020_0003 : 32'h0);
  assign w_busy     = r_state inside {GEN_A, GEN_B, SETTLE, CHECK};
  assign w_abort    = bus.abort && w_busy;
  // abort outranks start even when the sequencer is idle
  assign w_start    = bus.start && !bus.abort && (r_state == IDLE || r_state == DONE);
  assign w_last     = (r_state == SETTLE) ? (r_cnt == 4'(SETTLE_CYCLES - 1)) : (r_cnt == 4'(K - 1));
  assign w_test_inc = r_test + 1'b1;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: w_next = w_start ? GEN_A : r_state;
      GEN_A:      w_next = w_last ? GEN_B : GEN_A;
      GEN_B:      w_next = w_last ? SETTLE : GEN_B;
      SETTLE:     w_next = w_last ? CHECK : SETTLE;
      CHECK:      w_next = (w_test_inc == CNT_W'(NUM_TESTS)) ? DONE : GEN_A;
      default:    w_next = IDLE;
    endcase
    if (w_abort) w_next = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next != r_state) ? 4'd0 : r_cnt + 4'd1;
    end
  end
  // Shadows shift one 32-bit draw in per cycle; truncating to WIDTH leaves the
  // first draw in the most significant word once all K draws are in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= 32'h1;
      r_sh_a <= '0;
      r_sh_b <= '0;
      r_op_a <= '0;
      r_op_b <= '0;
      r_test <= '0;
      r_pass <= '0;
      r_fail <= '0;
      r_ffi  <= '0;
      r_ffv  <= 1'b0;
    end else if (w_start) begin
      r_lfsr <= (bus.seed == 32'h0) ? 32'h1 : bus.seed;
      r_test <= '0;
      r_pass <= '0;
      r_fail <= '0;
      r_ffi  <= '0;
      r_ffv  <= 1'b0;
    end else if (!w_abort) begin
      if (r_state == GEN_A) begin
        r_lfsr <= w_draw;
        r_sh_a <= WIDTH'({r_sh_a, w_draw});
      end
      if (r_state == GEN_B) begin
        r_lfsr <= w_draw;
        r_sh_b <= WIDTH'({r_sh_b, w_draw});
        if (w_last) begin
          r_op_a <= r_sh_a;
          r_op_b <= WIDTH'({r_sh_b, w_draw});
        end
      end
      if (r_state == CHECK) begin
        r_test <= w_test_inc;
        if (bus.ref_sum == bus.dut_sum) r_pass <= r_pass + 1'b1;
        else begin
          r_fail <= r_fail + 1'b1;
          if (!r_ffv) begin
            r_ffi <= r_test;
            r_ffv <= 1'b1;
          end
        end
      end
    end
  end
  assign bus.op_a           = r_op_a;
  assign bus.op_b           = r_op_b;
  assign bus.busy           = w_busy;
  assign bus.done           = r_state == DONE;
  assign bus.all_pass       = (r_state == DONE) && (r_fail == '0) && (r_test == CNT_W'(NUM_TESTS));
  assign bus.test_count     = r_test;
  assign bus.pass_count     = r_pass;
  assign bus.fail_count     = r_fail;
  assign bus.first_fail_idx = r_ffi;
  assign bus.first_fail_vld = r_ffv;
endmodule

// File: tb/tb_adder_bist_ctrl.sv
// tb_adder_bist_ctrl: directed self-checking bench for adder_bist_ctrl (8/32/64-bit instances).
module tb_adder_bist_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  always #5 clk = ~clk;
  adder_bist_ctrl_if #(.WIDTH(8),  .CNT_W(16)) ia();
  adder_bist_ctrl_if #(.WIDTH(32), .CNT_W(16)) ib();
  adder_bist_ctrl_if #(.WIDTH(64), .CNT_W(16)) ic();
  assign ia.ref_sum = ia.op_a + ia.op_b;
  assign ia.dut_sum = ia.op_a + ia.op_b;
  assign ib.ref_sum = ib.op_a + ib.op_b;
  assign ib.dut_sum = ib.op_a + ib.op_b;
  assign ic.ref_sum = ic.op_a + ic.op_b;
  assign ic.dut_sum = (ic.op_a + ic.op_b) & 64'h7FFF_FFFF_FFFF_FFFF;
  adder_bist_ctrl #(.WIDTH(8), .NUM_TESTS(10000), .SETTLE_CYCLES(1), .CNT_W(16)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(ia));
  adder_bist_ctrl #(.WIDTH(32), .NUM_TESTS(4), .SETTLE_CYCLES(3), .CNT_W(16)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(ib));
  adder_bist_ctrl #(.WIDTH(64), .NUM_TESTS(200), .SETTLE_CYCLES(1), .CNT_W(16)) u_c (
    .clk(clk), .rst_n(rst_n), .bus(ic));

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    ia.start = 0; ia.abort = 0; ia.seed = 0;
    ib.start = 0; ib.abort = 0; ib.seed = 0;
    ic.start = 0; ic.abort = 0; ic.seed = 0;
    cyc(2);
    total++;
    if ({ia.busy, ia.done, ia.all_pass, ia.first_fail_vld} !== 4'b0 || ia.op_a !== 8'h0 || ia.op_b !== 8'h0 ||
        ia.test_count !== 16'd0 || ia.pass_count !== 16'd0 || ia.fail_count !== 16'd0 || ia.first_fail_idx !== 16'd0) begin
      bad++; $display("FAIL reset_a: busy=%0b done=%0b op_a=%h tc=%0d, expected all zero", ia.busy, ia.done, ia.op_a, ia.test_count);
    end
    total++;
    if ({ib.busy, ib.done, ic.busy, ic.done} !== 4'b0 || ic.op_a !== 64'h0 || ic.test_count !== 16'd0) begin
      bad++; $display("FAIL reset_bc: b.busy=%0b c.busy=%0b c.op_a=%h, expected zero", ib.busy, ic.busy, ic.op_a);
    end
    rst_n = 1'b1;
    cyc(1);
  endtask

  task automatic start_a(input logic [31:0] s);
    ia.seed = s; ia.start = 1'b1;
    cyc(1);
    ia.start = 1'b0;
  endtask

  task automatic abort_a;
    ia.abort = 1'b1;
    cyc(1);
    ia.abort = 1'b0;
  endtask

  task automatic check_first_vec_a(input string tag);
    cyc(2);
    total++;
    if (ia.op_a !== 8'h03 || ia.op_b !== 8'h02 || ia.ref_sum !== 8'h05 || ia.busy !== 1'b1) begin
      bad++; $display("FAIL %s_ops: op_a=%h op_b=%h sum=%h busy=%0b, expected 03 02 05 1", tag, ia.op_a, ia.op_b, ia.ref_sum, ia.busy);
    end
    cyc(2);
    total++;
    if (ia.test_count !== 16'd1 || ia.pass_count !== 16'd1 || ia.fail_count !== 16'd0) begin
      bad++; $display("FAIL %s_count: tc=%0d pc=%0d fc=%0d, expected 1 1 0", tag, ia.test_count, ia.pass_count, ia.fail_count);
    end
  endtask

  task automatic test_first_vector;
    start_a(32'h1);
    total++;
    if (ia.busy !== 1'b1 || ia.test_count !== 16'd0) begin
      bad++; $display("FAIL first_start: busy=%0b tc=%0d, expected 1 0", ia.busy, ia.test_count);
    end
    check_first_vec_a("first");
    abort_a;
  endtask

  task automatic test_abort;
    start_a(32'h7);
    cyc(20);
    total++;
    if (ia.test_count !== 16'd5 || ia.busy !== 1'b1) begin
      bad++; $display("FAIL abort_pre: tc=%0d busy=%0b, expected 5 1", ia.test_count, ia.busy);
    end
    ia.abort = 1'b1;
    cyc(1);
    total++;
    if (ia.busy !== 1'b0 || ia.done !== 1'b0 || ia.test_count !== 16'd5 || ia.pass_count !== 16'd5) begin
      bad++; $display("FAIL abort_idle: busy=%0b done=%0b tc=%0d pc=%0d, expected 0 0 5 5", ia.busy, ia.done, ia.test_count, ia.pass_count);
    end
    ia.start = 1'b1;
    cyc(3);
    total++;
    if (ia.busy !== 1'b0 || ia.test_count !== 16'd5) begin
      bad++; $display("FAIL abort_prio: busy=%0b tc=%0d, expected 0 5", ia.busy, ia.test_count);
    end
    ia.start = 1'b0; ia.abort = 1'b0;
    start_a(32'h0);
    total++;
    if (ia.test_count !== 16'd0 || ia.pass_count !== 16'd0 || ia.busy !== 1'b1) begin
      bad++; $display("FAIL abort_restart: tc=%0d pc=%0d busy=%0b, expected 0 0 1", ia.test_count, ia.pass_count, ia.busy);
    end
    check_first_vec_a("seed0");
    abort_a;
  endtask

  task automatic test_async_reset;
    start_a(32'h1);
    cyc(6);
    total++;
    if (ia.test_count !== 16'd1 || ia.op_a === 8'h0) begin
      bad++; $display("FAIL areset_pre: tc=%0d op_a=%h, expected 1 and nonzero", ia.test_count, ia.op_a);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (ia.busy !== 1'b0 || ia.op_a !== 8'h0 || ia.op_b !== 8'h0 || ia.test_count !== 16'd0 || ia.pass_count !== 16'd0) begin
      bad++; $display("FAIL areset_low: busy=%0b op_a=%h op_b=%h tc=%0d, expected zero", ia.busy, ia.op_a, ia.op_b, ia.test_count);
    end
    rst_n = 1'b1;
    #1;
    total++;
    if (ia.busy !== 1'b0 || ia.done !== 1'b0 || ia.test_count !== 16'd0) begin
      bad++; $display("FAIL areset_rel: busy=%0b done=%0b tc=%0d, expected zero", ia.busy, ia.done, ia.test_count);
    end
    cyc(2);
    total++;
    if (ia.busy !== 1'b0) begin
      bad++; $display("FAIL areset_idle: busy=%0b, expected 0", ia.busy);
    end
    start_a(32'h1);
    check_first_vec_a("areset");
    abort_a;
  endtask

  task automatic test_full_run;
    int c = 0;
    start_a(32'h1);
    while (ia.done !== 1'b1 && c < 40010) begin
      cyc(1);
      c++;
    end
    total++;
    if (c != 40000) begin
      bad++; $display("FAIL full_latency: done after %0d cycles, expected 40000", c);
    end
    total++;
    if (ia.pass_count !== 16'd10000 || ia.fail_count !== 16'd0 || ia.test_count !== 16'd10000 ||
        ia.all_pass !== 1'b1 || ia.first_fail_vld !== 1'b0 || ia.busy !== 1'b0) begin
      bad++; $display("FAIL full_stats: pc=%0d fc=%0d tc=%0d ap=%0b ffv=%0b, expected 10000 0 10000 1 0",
                      ia.pass_count, ia.fail_count, ia.test_count, ia.all_pass, ia.first_fail_vld);
    end
    cyc(3);
    total++;
    if (ia.done !== 1'b1 || ia.test_count !== 16'd10000) begin
      bad++; $display("FAIL full_hold: done=%0b tc=%0d, expected 1 10000", ia.done, ia.test_count);
    end
  endtask

  task automatic test_stuck_bit;
    logic [31:0] s = 32'h1;
    logic [31:0] d1, d2, d3, d4;
    logic [63:0] sum;
    int exp_fail = 0;
    int exp_idx = -1;
    int c = 6;
    for (int i = 0; i < 200; i++) begin
      s = lfsr_step(s); d1 = s;
      s = lfsr_step(s); d2 = s;
      s = lfsr_step(s); d3 = s;
      s = lfsr_step(s); d4 = s;
      sum = {d1, d2} + {d3, d4};
      if (sum[63]) begin
        exp_fail++;
        if (exp_idx < 0) exp_idx = i;
      end
    end
    ic.seed = 32'h1; ic.start = 1'b1;
    cyc(1);
    ic.start = 1'b0;
    cyc(4);
    total++;
    if (ic.op_a !== 64'h8020_0003_C030_0002 || ic.op_b !== 64'h6018_0001_B02C_0003) begin
      bad++; $display("FAIL stuck_ops: op_a=%h op_b=%h, expected 80200003c0300002 60180001b02c0003", ic.op_a, ic.op_b);
    end
    cyc(2);
    total++;
    if (ic.fail_count !== 16'd1 || ic.pass_count !== 16'd0 || ic.first_fail_vld !== 1'b1 || ic.first_fail_idx !== 16'd0) begin
      bad++; $display("FAIL stuck_first: fc=%0d pc=%0d ffv=%0b ffi=%0d, expected 1 0 1 0",
                      ic.fail_count, ic.pass_count, ic.first_fail_vld, ic.first_fail_idx);
    end
    while (ic.done !== 1'b1 && c < 1300) begin
      cyc(1);
      c++;
    end
    total++;
    if (c != 1200) begin
      bad++; $display("FAIL stuck_latency: done after %0d cycles, expected 1200", c);
    end
    total++;
    if (ic.fail_count !== 16'(exp_fail) || ic.pass_count !== 16'(200 - exp_fail) || ic.test_count !== 16'd200 ||
        ic.first_fail_idx !== 16'(exp_idx) || ic.all_pass !== 1'b0 || ic.fail_count === 16'd0) begin
      bad++; $display("FAIL stuck_stats: fc=%0d pc=%0d tc=%0d ffi=%0d ap=%0b, expected fc=%0d pc=%0d tc=200 ffi=%0d ap=0",
                      ic.fail_count, ic.pass_count, ic.test_count, ic.first_fail_idx, ic.all_pass, exp_fail, 200 - exp_fail, exp_idx);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] prev_a;
    logic [31:0] prev_b;
    ib.seed = 32'h1; ib.start = 1'b1;
    cyc(1);
    ib.start = 1'b0;
    prev_a = ib.op_a;
    prev_b = ib.op_b;
    for (int c = 1; c <= 24; c++) begin
      ib.start = (c == 3 || c == 9);
      ib.seed = 32'hDEAD_BEEF;
      cyc(1);
      total++;
      if (((ib.op_a !== prev_a) || (ib.op_b !== prev_b)) !== (c % 6 == 2)) begin
        bad++; $display("FAIL b2b_stable c=%0d: op_a %h->%h op_b %h->%h, change expected=%0b",
                        c, prev_a, ib.op_a, prev_b, ib.op_b, c % 6 == 2);
      end
      total++;
      if (ib.test_count !== 16'(c / 6) || ib.done !== (c == 24)) begin
        bad++; $display("FAIL b2b_count c=%0d: tc=%0d done=%0b, expected %0d %0b", c, ib.test_count, ib.done, c / 6, c == 24);
      end
      if (c == 2) begin
        total++;
        if (ib.op_a !== 32'h8020_0003 || ib.op_b !== 32'hC030_0002) begin
          bad++; $display("FAIL b2b_first: op_a=%h op_b=%h, expected 80200003 c0300002", ib.op_a, ib.op_b);
        end
      end
      prev_a = ib.op_a;
      prev_b = ib.op_b;
    end
    ib.start = 1'b0;
    total++;
    if (ib.all_pass !== 1'b1 || ib.pass_count !== 16'd4) begin
      bad++; $display("FAIL b2b_end: ap=%0b pc=%0d, expected 1 4", ib.all_pass, ib.pass_count);
    end
  endtask

  initial begin
    test_reset;
    test_first_vector;
    test_abort;
    test_async_reset;
    test_full_run;
    test_stuck_bit;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/adder_bist_ctrl.md
Name: adder_bist_ctrl

Overview:
- Built-in self-test sequencer for the adder family (prefix, Jackson, Ling; 8–64 bit).
- Generates pseudo-random operand pairs from an internal LFSR and drives them to a golden mod-2^WIDTH adder and a device-under-test adder in parallel.
- Waits a programmable settle time, compares the two sums, and accumulates pass/fail statistics.
- Used for on-silicon/FPGA sign-off of each adder architecture, without a simulator.

Parameters:
- WIDTH, 64: operand/sum width; legal 8..64.
- NUM_TESTS, 10000: test vectors per run; legal 1..65535.
- SETTLE_CYCLES, 1: cycles operands are held stable before compare; legal 1..15.
- CNT_W, 16: width of test/pass/fail counters.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  1-cycle pulse; begins a run. Ignored unless state is IDLE or DONE.
- abort  in  1  level; returns FSM to IDLE on the next edge. Counters are kept.
- seed  in  32  LFSR seed, loaded on an accepted start.
- ref_sum  in  WIDTH  golden adder sum.
- dut_sum  in  WIDTH  DUT adder sum.
- op_a  out  WIDTH  operand A to both adders.
- op_b  out  WIDTH  operand B to both adders.
- busy  out  1  high in GEN_A/GEN_B/SETTLE/CHECK.
- done  out  1  high in DONE, until the next start or reset.
- all_pass  out  1  valid when done=1; 1 iff fail_count==0 and test_count==NUM_TESTS.
- test_count  out  CNT_W  vectors checked.
- pass_count  out  CNT_W  matching vectors.
- fail_count  out  CNT_W  mismatching vectors.
- first_fail_idx  out  CNT_W  test_count value at the first mismatch.
- first_fail_vld  out  1  a mismatch has been recorded in this run.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; LFSR=32'h1; all outputs and counters 0. Any state is forced to IDLE immediately.
- LFSR: 32-bit Galois, right shift, mask 32'h80200003.
  - next = (s>>1) ^ (s[0] ? 32'h80200003 : 0).
  - Seed 0 is replaced by 32'h1.
  - Each draw advances the LFSR first, then uses the new state.
- Operand build: K = ceil(WIDTH/32) draws per operand.
  - The first draw is placed in the most significant word.
  - The operand is the low WIDTH bits of the concatenation.
- FSM:
  - IDLE/DONE + start → GEN_A. On this edge: load seed; clear counters and first_fail_*; done=0.
  - GEN_A: K cycles, one draw per cycle into op_a shadow register. Then → GEN_B.
  - GEN_B: K cycles into op_b shadow. On the last cycle, op_a/op_b outputs are updated together → SETTLE.
  - op_a/op_b change only at that edge and never during SETTLE/CHECK.
  - SETTLE: hold SETTLE_CYCLES cycles → CHECK.
  - CHECK: 1 cycle; compare ref_sum==dut_sum combinationally.
    - test_count+1; pass_count+1 or fail_count+1.
    - On the first mismatch: first_fail_idx = pre-increment test_count; first_fail_vld=1.
    - If the new test_count==NUM_TESTS → DONE, else → GEN_A.
  - DONE: done=1; outputs hold.
  - abort=1 in any busy state → IDLE next edge. Counters frozen; done stays 0. abort has priority over start.
- Timing:
  - Cycles per vector = 2K + SETTLE_CYCLES + 1.
  - done rises exactly NUM_TESTS*(2K+SETTLE_CYCLES+1) cycles after the edge that accepted start.
- Invariants:
  - pass_count+fail_count==test_count at all times.
  - Counters never wrap, since NUM_TESTS < 2^CNT_W.
- start while busy: ignored. No restart.

Test Plan:
1. WIDTH=8, seed=1, ideal adders (ref and DUT both a+b mod 256).
   - First vector: op_a=8'h03 (LFSR 32'h80200003), op_b=8'h02 (LFSR 32'hC0300002), sums 8'h05.
   - pass_count increments at the first CHECK.
2. WIDTH=8, NUM_TESTS=10000, SETTLE=1, correct DUT.
   - done exactly 40000 cycles after start.
   - pass_count=10000, fail_count=0, all_pass=1.
3. WIDTH=64, DUT with a stuck-at-0 bit 63.
   - fail_count>0; first_fail_vld=1; first_fail_idx equals the index of the first vector whose reference sum has bit 63=1.
   - pass+fail=10000; all_pass=0.
4. rst_n pulsed low for 1 ns mid-SETTLE (asynchronous).
   - All outputs read 0 before the next clock edge; state=IDLE.
   - A new start reproduces scenario 1's first vector exactly.
5. abort at test_count=5, then start with seed=0.
   - Counters frozen at 5 and done=0 after abort.
   - The new run behaves identically to seed=1 (scenario 1 vectors) and counters clear to 0.
6. WIDTH=32, SETTLE=3, start pulsed while busy.
   - The run is not restarted; spacing is 6 cycles per vector.
   - op_a/op_b stable for all SETTLE+CHECK cycles.
